// File: rtl/count_dec_pkg.sv
// Shared types and defaults for the COUNT stream decoder.
// Event codes are visible on the ev_code port and must stay stable for status software.
package count_dec_pkg;

  localparam int DEF_W  = 4;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_UNK,
    S_UP,
    S_DN
  } tracker_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HOLD,
    EV_UP,
    EV_DN,
    EV_RELOAD,
    EV_JUMP
  } ev_t;

endpackage

// File: rtl/sat_counter.sv
// Event statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_q,
  output logic          o_at_max
);

  logic [CW-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= '0;
    else if (i_clr)
      r_q <= '0;
    else if (i_inc && !o_at_max)
      r_q <= r_q + CW'(1);
  end

  assign o_q      = r_q;
  assign o_at_max = &r_q;

endmodule

// File: rtl/count_stream_decoder.sv
// Watches a 4-bit up/down loadable counter's COUNT output and classifies each
// sample as hold / step / end-of-range reload / parallel-load jump.
module count_stream_decoder
  import count_dec_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_sample_en,
  input  logic [W-1:0]  i_count_in,
  input  logic          i_clr,
  output logic          o_ev_valid,
  output ev_t           o_ev_code,
  output logic          o_dir_valid,
  output logic          o_dir_up,
  output logic [CW-1:0] o_up_steps,
  output logic [CW-1:0] o_dn_steps,
  output logic [CW-1:0] o_reloads,
  output logic [CW-1:0] o_jumps,
  output logic          o_sat_flag
);

  localparam logic [W-1:0] MAXV = '1;

  tracker_t     r_state;
  tracker_t     w_next;
  ev_t          w_ev;
  logic [W-1:0] r_prev;
  logic [W-1:0] w_delta;
  logic         r_ev_valid;
  ev_t          r_ev_code;
  logic         w_take;
  logic [3:0]   w_at_max;

  assign w_delta = i_count_in - r_prev;
  // A discarded sample (clr in the same cycle) must not touch state or stats.
  assign w_take  = i_sample_en && !i_clr;

  // Priority order matters: the end-of-range checks must beat the +/-1 step
  // checks so that MAX->0 going up (and 0->MAX going down) counts as RELOAD.
  always_comb begin
    w_ev   = EV_NONE;
    w_next = r_state;
    if (r_state == S_EMPTY) begin
      w_next = S_UNK;
    end else if (w_delta == '0) begin
      w_ev = EV_HOLD;
    end else if (r_prev == MAXV && r_state == S_UP && i_count_in != MAXV) begin
      w_ev = EV_RELOAD;
    end else if (r_prev == '0 && r_state == S_DN && i_count_in != '0) begin
      w_ev = EV_RELOAD;
    end else if (w_delta == W'(1)) begin
      w_ev   = EV_UP;
      w_next = S_UP;
    end else if (w_delta == MAXV) begin
      w_ev   = EV_DN;
      w_next = S_DN;
    end else begin
      w_ev   = EV_JUMP;
      w_next = S_UNK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_prev     <= '0;
      r_ev_valid <= 1'b0;
      r_ev_code  <= EV_NONE;
    end else if (i_clr) begin
      r_state    <= S_EMPTY;
      r_prev     <= '0;
      r_ev_valid <= 1'b0;
      r_ev_code  <= EV_NONE;
    end else if (i_sample_en) begin
      r_state    <= w_next;
      r_prev     <= i_count_in;
      r_ev_valid <= (w_ev != EV_NONE);
      r_ev_code  <= w_ev;
    end else begin
      r_ev_valid <= 1'b0;
      r_ev_code  <= EV_NONE;
    end
  end

  sat_counter #(.CW(CW)) u_up (
    .clk(clk), .rst(rst), .i_inc(w_take && w_ev == EV_UP), .i_clr(i_clr),
    .o_q(o_up_steps), .o_at_max(w_at_max[0])
  );
  sat_counter #(.CW(CW)) u_dn (
    .clk(clk), .rst(rst), .i_inc(w_take && w_ev == EV_DN), .i_clr(i_clr),
    .o_q(o_dn_steps), .o_at_max(w_at_max[1])
  );
  sat_counter #(.CW(CW)) u_reload (
    .clk(clk), .rst(rst), .i_inc(w_take && w_ev == EV_RELOAD), .i_clr(i_clr),
    .o_q(o_reloads), .o_at_max(w_at_max[2])
  );
  sat_counter #(.CW(CW)) u_jump (
    .clk(clk), .rst(rst), .i_inc(w_take && w_ev == EV_JUMP), .i_clr(i_clr),
    .o_q(o_jumps), .o_at_max(w_at_max[3])
  );

  // Counters only leave all-ones via clr/rst, the same as the flag, so the
  // OR of their saturation bits is already sticky.
  assign o_sat_flag  = |w_at_max;
  assign o_ev_valid  = r_ev_valid;
  assign o_ev_code   = r_ev_code;
  assign o_dir_valid = (r_state == S_UP) || (r_state == S_DN);
  assign o_dir_up    = (r_state == S_UP);

endmodule

// File: tb/tb_count_stream_decoder.sv
// Randomized and directed bench for count_stream_decoder against a
// rule-level reference model of the classification and statistics.
module tb_count_stream_decoder;
  import count_dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sampleEn = 1'b0;
  logic [3:0] countIn = '0;
  logic       clr = 1'b0;
  logic       evValid;
  ev_t        evCode;
  logic       dirValid;
  logic       dirUp;
  logic [7:0] upSteps;
  logic [7:0] dnSteps;
  logic [7:0] reloads;
  logic [7:0] jumps;
  logic       satFlag;

  int checks = 0;
  int failures = 0;

  // reference model: dir 0 = unknown, 1 = ascending, 2 = descending
  bit mHas;
  int mPrev;
  int mDir;
  bit mEvValid;
  int mEvCode;
  int mUp, mDn, mRel, mJmp;

  count_stream_decoder #(.W(4), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .i_sample_en(sampleEn), .i_count_in(countIn), .i_clr(clr),
    .o_ev_valid(evValid), .o_ev_code(evCode),
    .o_dir_valid(dirValid), .o_dir_up(dirUp),
    .o_up_steps(upSteps), .o_dn_steps(dnSteps),
    .o_reloads(reloads), .o_jumps(jumps),
    .o_sat_flag(satFlag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int satInc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic void modelReset();
    mHas = 0; mPrev = 0; mDir = 0; mEvValid = 0; mEvCode = int'(EV_NONE);
    mUp = 0; mDn = 0; mRel = 0; mJmp = 0;
  endfunction

  function automatic void modelStep(input bit se, input int cnt, input bit cl);
    int d;
    mEvValid = 0;
    mEvCode  = int'(EV_NONE);
    if (cl) begin
      modelReset();
    end else if (se) begin
      if (mHas) begin
        d = (cnt - mPrev + 16) % 16;
        mEvValid = 1;
        if (d == 0) mEvCode = int'(EV_HOLD);
        else if (mPrev == 15 && mDir == 1 && cnt != 15) mEvCode = int'(EV_RELOAD);
        else if (mPrev == 0 && mDir == 2 && cnt != 0) mEvCode = int'(EV_RELOAD);
        else if (d == 1) begin mEvCode = int'(EV_UP); mDir = 1; end
        else if (d == 15) begin mEvCode = int'(EV_DN); mDir = 2; end
        else begin mEvCode = int'(EV_JUMP); mDir = 0; end
        case (mEvCode)
          int'(EV_UP):     mUp  = satInc(mUp);
          int'(EV_DN):     mDn  = satInc(mDn);
          int'(EV_RELOAD): mRel = satInc(mRel);
          int'(EV_JUMP):   mJmp = satInc(mJmp);
          default: ;
        endcase
      end
      mHas  = 1;
      mPrev = cnt;
    end
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".ev_valid"}, int'(evValid), int'(mEvValid));
    if (mEvValid) checkOutput({tag, ".ev_code"}, int'(evCode), mEvCode);
    checkOutput({tag, ".dir_valid"}, int'(dirValid), int'(mDir != 0));
    if (mDir != 0) checkOutput({tag, ".dir_up"}, int'(dirUp), int'(mDir == 1));
    checkOutput({tag, ".up_steps"}, int'(upSteps), mUp);
    checkOutput({tag, ".dn_steps"}, int'(dnSteps), mDn);
    checkOutput({tag, ".reloads"}, int'(reloads), mRel);
    checkOutput({tag, ".jumps"}, int'(jumps), mJmp);
    checkOutput({tag, ".sat_flag"}, int'(satFlag),
                int'(mUp == 255 || mDn == 255 || mRel == 255 || mJmp == 255));
  endtask

  // Drive one cycle of inputs away from the edge, then check just after it.
  task automatic applyStimulus(input string tag, input bit se, input int cnt, input bit cl);
    sampleEn = se;
    countIn  = 4'(cnt);
    clr      = cl;
    @(posedge clk);
    #1;
    modelStep(se, cnt, cl);
    compareAll(tag);
    sampleEn = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic sampleList(input string tag, input int vals[$]);
    foreach (vals[i]) applyStimulus(tag, 1'b1, vals[i], 1'b0);
  endtask

  task automatic asyncReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    compareAll(tag);
    checkOutput({tag, ".ev_code_zero"}, int'(evCode), int'(EV_NONE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int v;
    int r;
    modelReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compareAll("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    sampleList("seqA", '{3, 4, 5});
    checkOutput("seqA.up_steps_const", int'(upSteps), 2);
    sampleList("seqB", '{14, 15, 9});
    sampleList("seqC", '{2, 1, 0, 12});
    sampleList("seqD", '{5, 6, 5, 5, 11});
    checkOutput("seqD.dir_valid_const", int'(dirValid), 0);
    applyStimulus("idle", 1'b0, 7, 1'b0);

    v = 11;
    for (int i = 0; i < 300; i++) begin
      v = (v + 1) % 16;
      applyStimulus("ramp", 1'b1, v, 1'b0);
    end
    checkOutput("ramp.up_sat_const", int'(upSteps), 255);
    checkOutput("ramp.sat_const", int'(satFlag), 1);
    applyStimulus("clrSample", 1'b1, 3, 1'b1);
    applyStimulus("afterClr", 1'b1, 4, 1'b0);

    sampleList("preRst", '{6, 7});
    asyncReset("asyncRst");
    applyStimulus("postRst8", 1'b1, 8, 1'b0);
    applyStimulus("postRst9", 1'b1, 9, 1'b0);
    checkOutput("postRst9.code_const", int'(evCode), int'(EV_UP));

    // Biased random walk: mostly steps, with holds, loads, gaps and rare clears.
    v = 0;
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(99);
      if (r < 35)      v = (v + 1) % 16;
      else if (r < 65) v = (v + 15) % 16;
      else if (r < 75) v = v;
      else             v = $urandom_range(15);
      applyStimulus("rand", ($urandom_range(9) != 0), v, ($urandom_range(199) == 0));
      if ($urandom_range(499) == 0) asyncReset("randRst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL timeout: got no-finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
